dff_pipe: RTL
=============

# dff_pipe

Parametrised successor to the single 4-bit D flip-flop register: a DEPTH-stage, WIDTH-bit pipeline delay line with per-stage valid tracking, global stall, synchronous flush, a programmable reset value and an occupancy count. It sits wherever the datapath needs a fixed, stallable latency, for example to align operands with a multi-cycle unit. All state resets asynchronously.

## Interface
Parameters:
- WIDTH, default 4: data width in bits, ≥1.
- DEPTH, default 3: number of register stages, ≥1.
- RST_VAL, default 0: WIDTH-bit value loaded into every data stage on reset and on flush.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- en  input  1  advance enable; 0 = whole pipeline holds.
- flush  input  1  synchronous clear of all stages; has priority over en.
- in_valid  input  1  din carries a valid item this cycle.
- din  input  WIDTH  input data.
- out_valid  output  1  valid bit of the last stage.
- dout  output  WIDTH  data of the last stage.
- busy  output  1  1 when any stage is valid.
- occ  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

## Operation
- State: data stages d[0..DEPTH-1] and valid bits v[0..DEPTH-1]. Stage 0 is the input end and stage DEPTH-1 drives dout/out_valid.
- rst=0: every d[k] is set to RST_VAL, every v[k] to 0 and occ to 0, asynchronously. The block stays in this state while rst=0. Outputs while in reset: dout=RST_VAL, out_valid=0, busy=0, occ=0.
- Rising edge, rst=1, priority order:
  - flush=1: every d[k] <= RST_VAL, every v[k] <= 0, occ <= 0. The current din/in_valid is discarded, whatever en is.
  - flush=0, en=1: d[0] <= din, v[0] <= in_valid. For k≥1, d[k] <= d[k-1] and v[k] <= v[k-1]. Data shifts whether or not it is valid. The item in the last stage leaves.
  - flush=0, en=0: all d, v and occ hold. din/in_valid are ignored, and an item offered while en=0 is dropped.
- occ must equal the popcount of v[] at all times. With en=1 its update is occ + in_valid − v[DEPTH-1]. The result never exceeds DEPTH and never goes below 0.
- busy = (occ != 0). It is combinational from registered state.
- dout and out_valid come straight from the last stage's registers, with no combinational path from any input.
- DEPTH=1: the block is a single enabled register with valid. occ is 1 bit wide.

## Timing
- Latency: an item accepted at edge N (en=1, flush=0, in_valid=1) appears on dout with out_valid=1 after edge N+DEPTH−1. This holds provided en=1 at every intervening edge, so the item is visible during the cycle after DEPTH accepting edges.
- Each edge with en=0 adds exactly one cycle of latency to every item in flight.
- With en held at 1, out_valid is high for exactly one cycle per accepted item. Back-to-back items give back-to-back out_valid.
- flush takes effect at the edge where it is sampled. In the following cycle out_valid=0, busy=0, occ=0 and dout=RST_VAL.
- flush and en together: flush wins.
- Reset asserted mid-operation loses all in-flight items immediately, with no edge needed.
- Reset is released asynchronously. The first update happens at the first rising edge with rst=1.

## Test plan
- Reset: WIDTH=4, DEPTH=3, RST_VAL=4'h5. Drive rst=0 while clk is idle -> immediately dout=4'h5, out_valid=0, busy=0, occ=0.
- Latency: en=1. Present din=4'hA with in_valid=1 for one cycle, then in_valid=0 -> out_valid=1 and dout=4'hA exactly 3 edges later, for one cycle. occ reads 1,1,1 then 0.
- Stall: stream 4'h1,4'h2,4'h3 with en=1, then hold en=0 for 2 cycles with in_valid=1 and din=4'hF -> outputs freeze, occ stays 3, 4'hF never appears. After en returns to 1, the order out is 1,2,3.
- Full and occupancy: feed DEPTH consecutive valid items with en=1 -> occ=3 and busy=1. Keep in_valid=1 -> occ stays 3 while items stream out one per cycle.
- Flush: with occ=2, assert flush=1, en=1, in_valid=1, din=4'h7 -> next cycle occ=0, out_valid=0, dout=RST_VAL, and 4'h7 never emerges.
- Reset mid-stream and DEPTH=1: with occ=3, pulse rst=0 between edges -> state clears instantly. Separately, with DEPTH=1, din=4'hC and in_valid=1 -> dout=4'hC and out_valid=1 after one edge.

Source files
------------

// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
//   Stallable, flushable WIDTH-bit delay line of DEPTH register stages. Each
//   stage carries a valid bit, and a running occupancy count tracks how many
//   stages hold valid items. It provides a fixed latency (DEPTH edges with
//   en=1) for aligning operands with multi-cycle units.
//
// Parameters
//   WIDTH    data width in bits (>=1)
//   DEPTH    number of register stages (>=1)
//   RST_VAL  value loaded into every data stage on reset and on flush
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         advance enable; 0 holds the whole pipeline
//   flush      synchronous clear of all stages, overrides en
//   in_valid   din carries a valid item this cycle
//   din        input data
//   out_valid  valid bit of the last stage
//   dout       data of the last stage
//   busy       any stage valid
//   occ        number of valid stages, 0..DEPTH
// -----------------------------------------------------------------------------
module dff_pipe #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             din,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             dout,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] d_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_nxt;

  // Next occupancy while advancing: one item may enter and one may leave in
  // the same edge. Modular arithmetic at OCC_W bits gives the exact result
  // because the true value always lies in 0..DEPTH.
  always_comb begin
    occ_nxt = occ_q + OCC_W'(in_valid) - OCC_W'(vld_p[DEPTH-1]);
  end

  // ---- stage 0 .. DEPTH-1: data/valid shift register and occupancy ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        d_p[k] <= RST_VAL;
      end
      vld_p <= '0;
      occ_q <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        d_p[k] <= RST_VAL;
      end
      vld_p <= '0;
      occ_q <= '0;
    end else if (en) begin
      d_p[0]   <= din;
      vld_p[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        d_p[k]   <= d_p[k-1];
        vld_p[k] <= vld_p[k-1];
      end
      occ_q <= occ_nxt;
    end
  end

  // ---- outputs: straight from last-stage registers ----
  assign dout      = d_p[DEPTH-1];
  assign out_valid = vld_p[DEPTH-1];
  assign occ       = occ_q;
  assign busy      = (occ_q != '0);

endmodule
